// File: rtl/asp_dma_wr_cmpl_gen.sv
// DMA write-path completion generator: forwards one descriptor's worth of DMA write beats,
// then injects a fenced completion write of the magic value and pulses done_irq.
module asp_dma_wr_cmpl_gen #(
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_WIDTH = 7,
    parameter int LEN_WIDTH   = 24,
    parameter int MAGIC_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [LEN_WIDTH-1:0]      desc_len,
    input  logic [ADDR_WIDTH-1:0]     desc_cmpl_addr,
    input  logic [MAGIC_WIDTH-1:0]    desc_magic,
    input  logic                      up_write,
    input  logic [ADDR_WIDTH-1:0]     up_address,
    input  logic [BURST_WIDTH-1:0]    up_burstcount,
    input  logic [DATA_WIDTH-1:0]     up_writedata,
    input  logic [DATA_WIDTH/8-1:0]   up_byteenable,
    output logic                      up_waitrequest,
    output logic                      dn_write,
    output logic [ADDR_WIDTH-1:0]     dn_address,
    output logic [BURST_WIDTH-1:0]    dn_burstcount,
    output logic [DATA_WIDTH-1:0]     dn_writedata,
    output logic [DATA_WIDTH/8-1:0]   dn_byteenable,
    input  logic                      dn_waitrequest,
    output logic                      wr_fence_flag,
    output logic                      done_irq,
    output logic                      busy,
    output logic                      err_overrun
);
    // state | meaning
    // IDLE  | waiting for a descriptor; upstream stalled
    // DATA  | forwarding DMA beats, counting down beats_left
    // CMPL  | presenting the fenced completion write until accepted
    typedef enum logic [1:0] {IDLE, DATA, CMPL} state_t;

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [BE_WIDTH-1:0] CMPL_BE = BE_WIDTH'({(MAGIC_WIDTH/8){1'b1}});

    state_t                  state;
    state_t                  state_nxt;
    logic [LEN_WIDTH-1:0]    beats_left;
    logic [BURST_WIDTH-1:0]  burst_left;
    logic [ADDR_WIDTH-1:0]   cmpl_addr_q;
    logic [MAGIC_WIDTH-1:0]  magic_q;
    logic                    done_irq_q;
    logic                    err_q;
    logic                    accept;
    logic                    burst_first;
    logic                    last_beat;

    assign accept      = dn_write & ~dn_waitrequest;
    assign burst_first = (burst_left == '0);
    assign last_beat   = (beats_left == LEN_WIDTH'(1));
    assign done_irq    = done_irq_q;
    assign err_overrun = err_q;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (desc_valid) begin
                    state_nxt = (desc_len != '0) ? DATA : CMPL;
                end
            end
            DATA: begin
                if (accept && last_beat) begin
                    state_nxt = CMPL;
                end
            end
            CMPL: begin
                if (accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        desc_ready     = 1'b0;
        up_waitrequest = 1'b1;
        dn_write       = 1'b0;
        dn_address     = '0;
        dn_burstcount  = '0;
        dn_writedata   = '0;
        dn_byteenable  = '0;
        wr_fence_flag  = 1'b0;
        case (state)
            IDLE: begin
                desc_ready = 1'b1;
            end
            DATA: begin
                up_waitrequest = dn_waitrequest;
                dn_write       = up_write;
                dn_address     = up_address;
                dn_burstcount  = up_burstcount;
                dn_writedata   = up_writedata;
                dn_byteenable  = up_byteenable;
            end
            CMPL: begin
                dn_write      = 1'b1;
                dn_address    = cmpl_addr_q;
                dn_burstcount = BURST_WIDTH'(1);
                dn_writedata  = DATA_WIDTH'(magic_q);
                dn_byteenable = CMPL_BE;
                wr_fence_flag = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beats_left  <= '0;
            burst_left  <= '0;
            cmpl_addr_q <= '0;
            magic_q     <= '0;
            done_irq_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_irq_q <= (state == CMPL) && accept;
            if (state == IDLE && desc_valid) begin
                beats_left  <= desc_len;
                burst_left  <= '0;
                cmpl_addr_q <= desc_cmpl_addr;
                magic_q     <= desc_magic;
            end else if (state == DATA && accept) begin
                beats_left <= beats_left - LEN_WIDTH'(1);
                // The last beat drops any unfinished burst so the next descriptor starts clean
                if (last_beat) begin
                    burst_left <= '0;
                end else if (burst_first) begin
                    burst_left <= up_burstcount - BURST_WIDTH'(1);
                end else begin
                    burst_left <= burst_left - BURST_WIDTH'(1);
                end
                if (burst_first && (LEN_WIDTH'(up_burstcount) > beats_left)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_asp_dma_wr_cmpl_gen.sv
// Self-checking bench for asp_dma_wr_cmpl_gen: randomized DMA bursts and downstream stalls
// compared against a beat-list model of the expected downstream write sequence.
module tb_asp_dma_wr_cmpl_gen;
    localparam int AW  = 48;
    localparam int DW  = 512;
    localparam int BW  = 7;
    localparam int LW  = 24;
    localparam int MW  = 64;
    localparam int BEW = DW / 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           desc_valid;
    logic           desc_ready;
    logic [LW-1:0]  desc_len;
    logic [AW-1:0]  desc_cmpl_addr;
    logic [MW-1:0]  desc_magic;
    logic           up_write;
    logic [AW-1:0]  up_address;
    logic [BW-1:0]  up_burstcount;
    logic [DW-1:0]  up_writedata;
    logic [BEW-1:0] up_byteenable;
    logic           up_waitrequest;
    logic           dn_write;
    logic [AW-1:0]  dn_address;
    logic [BW-1:0]  dn_burstcount;
    logic [DW-1:0]  dn_writedata;
    logic [BEW-1:0] dn_byteenable;
    logic           dn_waitrequest;
    logic           wr_fence_flag;
    logic           done_irq;
    logic           busy;
    logic           err_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_err = 1'b0;

    int             bursts[$];
    logic [AW-1:0]  ib_addr[$];
    logic [BW-1:0]  ib_bc[$];
    logic [DW-1:0]  ib_data[$];
    logic [BEW-1:0] ib_be[$];

    always #5 clk = ~clk;

    asp_dma_wr_cmpl_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .LEN_WIDTH(LW), .MAGIC_WIDTH(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
        .desc_cmpl_addr(desc_cmpl_addr), .desc_magic(desc_magic),
        .up_write(up_write), .up_address(up_address), .up_burstcount(up_burstcount),
        .up_writedata(up_writedata), .up_byteenable(up_byteenable), .up_waitrequest(up_waitrequest),
        .dn_write(dn_write), .dn_address(dn_address), .dn_burstcount(dn_burstcount),
        .dn_writedata(dn_writedata), .dn_byteenable(dn_byteenable), .dn_waitrequest(dn_waitrequest),
        .wr_fence_flag(wr_fence_flag), .done_irq(done_irq), .busy(busy), .err_overrun(err_overrun)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW / 32; i++) d = (d << 32) | DW'($urandom);
        return d;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'({$urandom, $urandom});
        return a & ~AW'(63);
    endfunction

    // Expand the burst list into the beat stream the DMA master intends to send.
    task automatic build_stream();
        logic [AW-1:0] a;
        ib_addr.delete(); ib_bc.delete(); ib_data.delete(); ib_be.delete();
        foreach (bursts[b]) begin
            a = rand_addr();
            for (int j = 0; j < bursts[b]; j++) begin
                ib_addr.push_back(a);
                ib_bc.push_back(BW'(bursts[b]));
                ib_data.push_back(rand_data());
                ib_be.push_back(BEW'({$urandom, $urandom}));
            end
        end
    endtask

    function automatic bit calc_overrun(input int len);
        int pos;
        pos = 0;
        foreach (bursts[b]) begin
            if (pos < len && bursts[b] > len - pos) return 1'b1;
            pos += bursts[b];
        end
        return 1'b0;
    endfunction

    task automatic drive_idle_up();
        up_write = 1'b0; up_address = '0; up_burstcount = '0; up_writedata = '0; up_byteenable = '0;
    endtask

    task automatic run_transfer(input string name, input int len, input logic [AW-1:0] caddr,
                                input logic [MW-1:0] magic, input int wait_pct, input int cmpl_stall);
        int idx, k, ref_cyc, pres_cyc, acc_cyc, desc_cyc, irqs, stalls;
        bit desc_done, finished, exp_busy;
        logic [DW-1:0] exp_cd;
        logic [BEW-1:0] exp_cbe;
        exp_cd  = DW'(magic);
        exp_cbe = BEW'({(MW/8){1'b1}});
        if (calc_overrun(len)) exp_err = 1'b1;
        idx = 0; k = 0; ref_cyc = -10; pres_cyc = -1; acc_cyc = -10; desc_cyc = -10;
        irqs = 0; stalls = 0; desc_done = 0; finished = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(posedge clk); #1;
            desc_valid = !desc_done; desc_len = LW'(len); desc_cmpl_addr = caddr; desc_magic = magic;
            if (idx < ib_addr.size()) begin
                up_write = 1'b1; up_address = ib_addr[idx]; up_burstcount = ib_bc[idx];
                up_writedata = ib_data[idx]; up_byteenable = ib_be[idx];
            end else begin
                drive_idle_up();
            end
            if (wr_fence_flag && stalls < cmpl_stall) begin
                dn_waitrequest = 1'b1; stalls++;
            end else if (wr_fence_flag) begin
                dn_waitrequest = 1'b0;
            end else begin
                dn_waitrequest = ($urandom_range(99) < wait_pct);
            end
            @(negedge clk);
            exp_busy = (desc_cyc >= 0 && cyc > desc_cyc) && !(acc_cyc >= 0 && cyc > acc_cyc);
            n_checks++;
            if (busy !== exp_busy || desc_ready !== !exp_busy) begin
                n_fail++;
                $display("FAIL %s busy/desc_ready cyc %0d: got %b/%b want %b/%b",
                         name, cyc, busy, desc_ready, exp_busy, !exp_busy);
            end
            if (dn_waitrequest && wr_fence_flag) begin
                n_checks++;
                if (dn_write !== 1'b1 || dn_address !== caddr || dn_burstcount !== BW'(1) ||
                    dn_writedata !== exp_cd || dn_byteenable !== exp_cbe || up_waitrequest !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s cmpl_hold cyc %0d: wr %b addr %h bc %0d data_lo %h be %h upwait %b want addr %h data_lo %h",
                             name, cyc, dn_write, dn_address, dn_burstcount, dn_writedata[63:0],
                             dn_byteenable, up_waitrequest, caddr, magic);
                end
            end
            if (pres_cyc < 0 && ref_cyc >= 0 && cyc > ref_cyc && k == len && dn_write) pres_cyc = cyc;
            if (!desc_done && desc_valid && desc_ready) begin
                desc_done = 1; desc_cyc = cyc;
                if (len == 0) ref_cyc = cyc;
            end
            if (dn_write && !dn_waitrequest) begin
                n_checks++;
                if (k < len) begin
                    if (dn_address !== ib_addr[k] || dn_burstcount !== ib_bc[k] || dn_writedata !== ib_data[k] ||
                        dn_byteenable !== ib_be[k] || wr_fence_flag !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s data_beat %0d: addr %h bc %0d data_lo %h be %h fence %b want addr %h bc %0d data_lo %h be %h fence 0",
                                 name, k, dn_address, dn_burstcount, dn_writedata[63:0], dn_byteenable,
                                 wr_fence_flag, ib_addr[k], ib_bc[k], ib_data[k][63:0], ib_be[k]);
                    end
                end else if (k == len) begin
                    acc_cyc = cyc;
                    if (dn_address !== caddr || dn_burstcount !== BW'(1) || dn_writedata !== exp_cd ||
                        dn_byteenable !== exp_cbe || wr_fence_flag !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s cmpl_write: addr %h bc %0d data_lo %h be %h fence %b want addr %h bc 1 data_lo %h be %h fence 1",
                                 name, dn_address, dn_burstcount, dn_writedata[63:0], dn_byteenable,
                                 wr_fence_flag, caddr, magic, exp_cbe);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL %s extra_write %0d: addr %h, want no write", name, k, dn_address);
                end
                k++;
                if (k == len && len > 0) ref_cyc = cyc;
            end
            if (up_write && !up_waitrequest) idx++;
            n_checks++;
            if (done_irq !== (acc_cyc >= 0 && cyc == acc_cyc + 1)) begin
                n_fail++;
                $display("FAIL %s done_irq cyc %0d: got %b want %b (cmpl accepted cyc %0d)",
                         name, cyc, done_irq, !done_irq, acc_cyc);
            end
            if (done_irq === 1'b1) irqs++;
            if (acc_cyc >= 0 && cyc >= acc_cyc + 3) finished = 1;
        end
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d writes want %0d", name, k, len + 1);
        end
        n_checks++;
        if (k != len + 1 || irqs != 1 || idx != len) begin
            n_fail++;
            $display("FAIL %s counts: writes %0d irqs %0d up_beats %0d want %0d 1 %0d",
                     name, k, irqs, idx, len + 1, len);
        end
        n_checks++;
        if (pres_cyc != ref_cyc + 1) begin
            n_fail++;
            $display("FAIL %s cmpl_latency: presented cyc %0d want %0d", name, pres_cyc, ref_cyc + 1);
        end
        n_checks++;
        if (stalls != cmpl_stall) begin
            n_fail++;
            $display("FAIL %s cmpl_stall_cycles: got %0d want %0d", name, stalls, cmpl_stall);
        end
        n_checks++;
        if (err_overrun !== exp_err) begin
            n_fail++;
            $display("FAIL %s err_overrun: got %b want %b", name, err_overrun, exp_err);
        end
        @(posedge clk); #1;
        drive_idle_up(); desc_valid = 1'b0; dn_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; desc_valid = 1'b1; desc_len = LW'(5); desc_cmpl_addr = '1; desc_magic = '1;
        up_write = 1'b1; up_address = '1; up_burstcount = BW'(4); up_writedata = '1; up_byteenable = '1;
        dn_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (desc_ready !== 1'b1 || up_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: desc_ready %b up_waitrequest %b want 1 1", desc_ready, up_waitrequest);
        end
        n_checks++;
        if (dn_write !== 1'b0 || dn_address !== '0 || dn_burstcount !== '0 || dn_writedata !== '0 ||
            dn_byteenable !== '0) begin
            n_fail++;
            $display("FAIL reset_dn: wr %b addr %h bc %0d be %h want all 0",
                     dn_write, dn_address, dn_burstcount, dn_byteenable);
        end
        n_checks++;
        if (wr_fence_flag !== 1'b0 || done_irq !== 1'b0 || busy !== 1'b0 || err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: fence %b irq %b busy %b err %b want 0 0 0 0",
                     wr_fence_flag, done_irq, busy, err_overrun);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; desc_valid = 1'b0; drive_idle_up();
        exp_err = 1'b0;
    endtask

    task automatic test_single_burst();
        bursts = '{4}; build_stream();
        run_transfer("single_burst", 4, rand_addr(), 64'hDEADBEEF_CAFEF00D, 0, 0);
    endtask

    task automatic test_long_bursts();
        bursts = '{64, 64, 2}; build_stream();
        run_transfer("long_bursts", 130, rand_addr(), MW'({$urandom, $urandom}), 50, 0);
    endtask

    task automatic test_zero_len();
        bursts.delete(); build_stream();
        run_transfer("zero_len", 0, rand_addr(), MW'({$urandom, $urandom}), 0, 0);
    endtask

    task automatic test_cmpl_stall();
        bursts = '{2}; build_stream();
        run_transfer("cmpl_stall", 2, rand_addr(), MW'({$urandom, $urandom}), 20, 5);
    endtask

    task automatic test_random();
        int len, rem, s;
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(20);
            bursts.delete();
            rem = len;
            while (rem > 0) begin
                s = $urandom_range((rem < 8) ? rem : 8, 1);
                bursts.push_back(s);
                rem -= s;
            end
            build_stream();
            run_transfer($sformatf("random_%0d", t), len, rand_addr(), MW'({$urandom, $urandom}),
                         $urandom_range(60), $urandom_range(3));
        end
    endtask

    task automatic test_overrun();
        bursts = '{4}; build_stream();
        run_transfer("overrun", 3, rand_addr(), MW'({$urandom, $urandom}), 0, 0);
    endtask

    task automatic test_reset_mid();
        int acc;
        acc = 0;
        bursts = '{8}; build_stream();
        @(posedge clk); #1;
        desc_valid = 1'b1; desc_len = LW'(8); desc_cmpl_addr = rand_addr(); desc_magic = '1;
        dn_waitrequest = 1'b0; drive_idle_up();
        @(posedge clk); #1;
        desc_valid = 1'b0;
        for (int c = 0; c < 50 && acc < 2; c++) begin
            up_write = 1'b1; up_address = ib_addr[acc]; up_burstcount = ib_bc[acc];
            up_writedata = ib_data[acc]; up_byteenable = ib_be[acc];
            @(negedge clk);
            if (dn_write && !dn_waitrequest) acc++;
            if (acc == 2) reset_n = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL reset_mid_beats: forwarded %0d want 2", acc);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || desc_ready !== 1'b1 || dn_write !== 1'b0 || up_waitrequest !== 1'b1 ||
            done_irq !== 1'b0 || wr_fence_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_state: busy %b ready %b dn_write %b upwait %b irq %b fence %b want 0 1 0 1 0 0",
                     busy, desc_ready, dn_write, up_waitrequest, done_irq, wr_fence_flag);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; drive_idle_up();
        exp_err = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (done_irq !== 1'b0 || dn_write !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cyc %0d: irq %b dn_write %b want 0 0", c, done_irq, dn_write);
            end
        end
        bursts = '{2, 3}; build_stream();
        run_transfer("after_reset", 5, rand_addr(), MW'({$urandom, $urandom}), 30, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_long_bursts();
        test_zero_len();
        test_cmpl_stall();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
